pkg_gen: RTL and testbench



---
 rtl/pkg_gen.sv | 147 ++++++++++++++
 tb/tb_pkg_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_gen.sv
// pkg_gen: free-running test-packet generator for the 512-bit stream.
// Emits PKT_BEATS-beat packets of known content, separated by a
// programmable number of idle cycles, while io_start is held high.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no packet in flight, outputs zero, waiting for io_start
// SEND  | presenting a beat, advancing on valid & ready
// GAP   | inter-packet idle period, counting down the sampled gap
module pkg_gen #(
    parameter int PKT_BEATS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_start,
    input  logic [31:0]  io_idle_cycle,
    input  logic         io_data_out_ready,
    output logic         io_data_out_valid,
    output logic [511:0] io_data_out_bits_data,
    output logic [63:0]  io_data_out_bits_keep,
    output logic         io_data_out_bits_last
);

    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   beat, beat_n;
    logic [31:0]     seq, seq_n;
    logic [31:0]     gap_cnt, gap_cnt_n;
    logic            hs;
    logic            at_last;

    logic            valid_n;
    logic            last_n;
    logic [511:0]    data_n;
    logic [63:0]     keep_n;

    // Beat content: word0 = sequence number, word1 = beat index, word i = i.
    function automatic logic [511:0] payload(input logic [31:0] s, input logic [BW-1:0] b);
        logic [511:0] p;
        p = '0;
        p[31:0]  = s;
        p[63:32] = 32'(b);
        for (int i = 2; i < 16; i++) begin
            p[32*i +: 32] = 32'(i);
        end
        return p;
    endfunction

    // Next-state, counter and next-output computation.
    always_comb begin
        state_n   = state;
        beat_n    = beat;
        seq_n     = seq;
        gap_cnt_n = gap_cnt;
        hs        = io_data_out_valid & io_data_out_ready;
        at_last   = (beat == LAST_BEAT);

        case (state)
            IDLE: begin
                if (io_start) begin
                    state_n = SEND;
                    beat_n  = '0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!at_last) begin
                        beat_n = beat + 1'b1;
                    end else begin
                        beat_n = '0;
                        seq_n  = seq + 32'd1;
                        // Gap length is latched only here, so mid-packet
                        // changes to io_idle_cycle wait for this boundary.
                        if (io_idle_cycle != 32'd0) begin
                            state_n   = GAP;
                            gap_cnt_n = io_idle_cycle;
                        end else if (!io_start) begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt - 32'd1;
                if (gap_cnt <= 32'd1) begin
                    gap_cnt_n = '0;
                    state_n   = io_start ? SEND : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are computed from the upcoming state so they can be registered.
        valid_n = (state_n == SEND);
        data_n  = valid_n ? payload(seq_n, beat_n) : '0;
        keep_n  = valid_n ? '1 : '0;
        last_n  = valid_n && (beat_n == LAST_BEAT);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Beat, sequence and gap counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat    <= '0;
            seq     <= '0;
            gap_cnt <= '0;
        end else begin
            beat    <= beat_n;
            seq     <= seq_n;
            gap_cnt <= gap_cnt_n;
        end
    end

    // Registered stream outputs; they hold while a beat is backpressured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_data_out_valid     <= 1'b0;
            io_data_out_bits_data <= '0;
            io_data_out_bits_keep <= '0;
            io_data_out_bits_last <= 1'b0;
        end else begin
            io_data_out_valid     <= valid_n;
            io_data_out_bits_data <= data_n;
            io_data_out_bits_keep <= keep_n;
            io_data_out_bits_last <= last_n;
        end
    end

endmodule

// File: tb/tb_pkg_gen.sv
// tb_pkg_gen: scoreboard bench for pkg_gen with PKT_BEATS = 4.
module tb_pkg_gen;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         io_start = 1'b0;
    logic [31:0]  io_idle_cycle = 32'd0;
    logic         ready = 1'b0;
    logic         valid;
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;

    pkg_gen #(.PKT_BEATS(4)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_start              (io_start),
        .io_idle_cycle         (io_idle_cycle),
        .io_data_out_ready     (ready),
        .io_data_out_valid     (valid),
        .io_data_out_bits_data (data),
        .io_data_out_bits_keep (keep),
        .io_data_out_bits_last (last)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned seq;
        int unsigned b;
        int          delta;   // cycles since previous handshake, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [511:0] model(input int unsigned s, input int unsigned b);
        logic [511:0] p;
        p = '0;
        p[31:0]  = s;
        p[63:32] = b;
        for (int i = 2; i < 16; i++) p[32*i +: 32] = i;
        return p;
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks hold-stability.
    initial begin
        logic         p_stall;
        logic [511:0] pdata;
        logic         plast;
        int           last_hs;
        exp_t         e;
        logic [511:0] ed;
        logic         el;
        p_stall = 1'b0;
        pdata   = '0;
        plast   = 1'b0;
        last_hs = 0;
        forever begin
            @(negedge clock);
            if (p_stall) begin
                checks++;
                if (!(valid === 1'b1 && data === pdata && last === plast && keep === '1)) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d: got valid=%b last=%b word0=%0d word1=%0d, required valid=1 last=%b word0=%0d word1=%0d",
                             cyc, valid, last, data[31:0], data[63:32], plast, pdata[31:0], pdata[63:32]);
                end
            end
            if (valid === 1'b1 && ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat cyc=%0d: got word0=%0d word1=%0d last=%b, required no beat",
                             cyc, data[31:0], data[63:32], last);
                end else begin
                    e  = q.pop_front();
                    ed = model(e.seq, e.b);
                    el = (e.b == 3);
                    checks++;
                    if (data !== ed || keep !== 64'hFFFF_FFFF_FFFF_FFFF || last !== el) begin
                        errors++;
                        $display("FAIL beat_payload seq=%0d b=%0d: got word0=%0d word1=%0d keep=%h last=%b, required word0=%0d word1=%0d keep=%h last=%b",
                                 e.seq, e.b, data[31:0], data[63:32], keep, last,
                                 ed[31:0], ed[63:32], 64'hFFFF_FFFF_FFFF_FFFF, el);
                    end
                    if (e.delta >= 0) begin
                        checks++;
                        if (cyc - last_hs != e.delta) begin
                            errors++;
                            $display("FAIL beat_spacing seq=%0d b=%0d: got %0d cycles, required %0d",
                                     e.seq, e.b, cyc - last_hs, e.delta);
                        end
                    end
                end
                last_hs = cyc;
            end
            p_stall = (valid === 1'b1) && (ready !== 1'b1);
            pdata   = data;
            plast   = last;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Expect one packet: beat 0 at spacing d0, beat 1 at d1, beats 2..3 at 1.
    task automatic push_pkt(input int unsigned s, input int d0, input int d1);
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            e.seq   = s;
            e.b     = b;
            e.delta = (b == 0) ? d0 : ((b == 1) ? d1 : 1);
            q.push_back(e);
        end
    endtask

    task automatic push_beat(input int unsigned s, input int unsigned b, input int d);
        exp_t e;
        e.seq   = s;
        e.b     = b;
        e.delta = d;
        q.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        // Reset state
        step(2);
        chk("reset_valid", 512'(valid), 512'd0);
        chk("reset_last",  512'(last),  512'd0);
        chk("reset_data",  data,        512'd0);
        chk("reset_keep",  512'(keep),  512'd0);
        reset = 1'b1;
        step(5);
        chk("idle_valid", 512'(valid), 512'd0);
        chk("idle_data",  data,        512'd0);

        // Steady stream, gap 10: period 14
        io_idle_cycle = 32'd10;
        ready         = 1'b1;
        io_start      = 1'b1;
        push_pkt(0, -1, 1);
        push_pkt(1, 11, 1);
        push_pkt(2, 11, 1);
        wait_drain();
        io_start = 1'b0;
        step(15);

        // Backpressure: ready 1,0,0,1
        io_idle_cycle = 32'd3;
        io_start      = 1'b1;
        push_pkt(3, -1, 3);
        step(2);
        ready = 1'b0;
        step(2);
        ready = 1'b1;
        wait_drain();
        io_start = 1'b0;
        step(6);

        // Zero gap, then stop during beat 1 of seq 6
        io_idle_cycle = 32'd0;
        io_start      = 1'b1;
        push_pkt(4, -1, 1);
        push_pkt(5, 1, 1);
        push_pkt(6, 1, 1);
        step(10);
        io_start = 1'b0;
        wait_drain();
        step(20);
        chk("stopped_valid", 512'(valid), 512'd0);

        // Restart continues seq; async reset during beat 1 of seq 8
        io_idle_cycle = 32'd2;
        io_start      = 1'b1;
        push_pkt(7, -1, 1);
        push_beat(8, 0, 3);
        step(8);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 512'(valid), 512'd0);
        chk("async_rst_last",  512'(last),  512'd0);
        chk("async_rst_data",  data,        512'd0);
        step(2);
        reset = 1'b1;
        push_pkt(0, -1, 1);
        wait_drain();
        io_start = 1'b0;
        step(10);
        chk("final_valid", 512'(valid), 512'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
